txt_overlay_engine: RTL and testbench
=====================================

Name: txt_overlay_engine

Overview:
- Parametrised, pipelined text-overlay renderer; successor to the fixed per-scene text pixel generator.
- Holds NUM_LINES writable character lines and draws scaled glyphs from an external synchronous glyph ROM.
- Adds a blinking cursor box around a selected character and a per-frame "typewriter" reveal.
- Sits beside the sprite/scene pixel sources; the top-level mux selects pixel_out when valid=1.

Parameters:
- NUM_LINES, 2, number of text lines
- CHARS_PER_LINE, 8, character slots per line
- CHAR_W, 6, glyph ROM address width (code 0-9 digits, 10+ letters)
- SCALE_SHIFT, 4, log2 of screen pixels per glyph cell (5x7 cells become 80x112)
- CHAR_PITCH, 90, horizontal screen pixels between character origins (must be >= 5<<SCALE_SHIFT)
- BOX_W, 10, cursor-box stroke thickness in pixels
- BLINK_FRAMES, 32, frames per cursor blink half-period
- REVEAL_FRAMES, 4, frames per revealed character

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_cnt  in  10  current pixel x
- v_cnt  in  10  current pixel y
- frame_start  in  1  one-cycle pulse at start of each frame
- wr_en  in  1  write character
- wr_line  in  clog2(NUM_LINES)  target line
- wr_col  in  clog2(CHARS_PER_LINE)  target slot
- wr_char  in  CHAR_W  glyph code; all-ones = blank
- org_we  in  1  write line origin
- org_x, org_y  in  10 each  line top-left
- colour_in  in  12  line colour, written with org_we
- cursor_en  in  1  show cursor box
- cursor_line, cursor_col  in  index widths  cursor position
- reveal_start  in  1  restart typewriter reveal
- glyph_addr  out  CHAR_W  ROM char code
- glyph_col  out  3  cell column 0-4
- glyph_row  out  3  cell row 0-6
- glyph_bit  in  1  ROM output, valid one cycle after address
- pixel_out  out  12  RGB444 pixel
- valid  out  1  pixel belongs to overlay

Behaviour:
- Reset: every char slot = blank; origins = 0; colours = 12'hfff; pixel_out = 0; valid = 0; blink phase = on; reveal count = full (everything shown); frame and blink counters = 0.
- Character and origin writes take effect next cycle. A write in the same cycle as a read of that slot returns the old value.
- Pipeline, fixed latency 3 cycles from h_cnt/v_cnt to pixel_out/valid:
  - S0: for each line, hit when org_y <= v < org_y + (7<<SCALE_SHIFT). Lowest line index wins on overlap. Compute dx = h - org_x; col = dx / CHAR_PITCH (iterative compare against constant multiples, no divider); off = dx - col*CHAR_PITCH. Glyph hit when col < CHARS_PER_LINE and off < (5<<SCALE_SHIFT). Cell coordinates: off>>SCALE_SHIFT and dy>>SCALE_SHIFT. Box hit when cursor_en, the cursor line matches, and the pixel lies inside the cursor cell's outline expanded by BOX_W on each side but not in the glyph area.
  - S1: register char code, present glyph_addr/col/row to the ROM.
  - S2: glyph_bit returns. pixel_out = colour when bit=1, 0 otherwise.
- Output priority:
  - Box hit with blink phase on: pixel_out = 12'hfff, valid = 1.
  - Otherwise glyph hit with char not blank and col < reveal count: valid = 1, pixel_out as above.
  - Otherwise valid = 0, pixel_out = 0.
- Blink: frame counter increments on frame_start. At BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
- Reveal: reveal_start sets reveal count = 0 and clears the reveal frame counter. Every REVEAL_FRAMES frame_starts, reveal count +1, saturating at CHARS_PER_LINE. Reveal applies to all lines. reveal_start coincident with frame_start: reset wins.
- Coordinates left of or above the origin (negative dx/dy) are not hits; no wrap-around.
- Async reset mid-frame clears the pipeline: valid = 0 from the reset assertion until the first 3-cycle-old post-reset sample.

Test Plan:
- Reset, write line0 origin (160,28), chars {16,10,22,14} ("GAME"), ROM model returns 1 for all cells -> pixel (160,28) valid=1 pixel_out=fff three cycles later; (240,28) valid=0 (gap, pitch 90); (250,28) valid=1.
- Same setup, probe (160+79,28+111) valid=1 with glyph_col=4, glyph_row=6; probe (160,140) valid=0.
- Cursor on line0 col1, cursor_en=1 -> (245,28) white, box present. After 32 frame_start pulses the box pixels give valid=0; after 64 they are white again.
- reveal_start, then 8 frame_start -> cols 0-1 visible, col 2 valid=0; after 40 frames all 4 are visible and the count holds at 8.
- Two lines overlapping in y -> line0 colour is displayed. Write a char at the same cycle it is rendered -> old glyph, then the new one on the next frame.
- Assert rst_n low mid-line -> valid=0 immediately; all slots blank afterwards.

Source files
------------

// File: rtl/txt_overlay_engine.sv
// Text overlay renderer: NUM_LINES writable character lines drawn as scaled
// glyphs from an external synchronous ROM. It also draws a blinking cursor box
// and a per-frame typewriter reveal. The latency from h_cnt/v_cnt to
// pixel_out/valid is a fixed three cycles.
module txt_overlay_engine #(
    parameter int unsigned NUM_LINES      = 2,
    parameter int unsigned CHARS_PER_LINE = 8,
    parameter int unsigned CHAR_W         = 6,
    parameter int unsigned SCALE_SHIFT    = 4,
    parameter int unsigned CHAR_PITCH     = 90,
    parameter int unsigned BOX_W          = 10,
    parameter int unsigned BLINK_FRAMES   = 32,
    parameter int unsigned REVEAL_FRAMES  = 4,
    localparam int unsigned LW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int unsigned CIW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [LW-1:0]     wr_line,
    input  logic [CIW-1:0]    wr_col,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              org_we,
    input  logic [9:0]        org_x,
    input  logic [9:0]        org_y,
    input  logic [11:0]       colour_in,
    input  logic              cursor_en,
    input  logic [LW-1:0]     cursor_line,
    input  logic [CIW-1:0]    cursor_col,
    input  logic              reveal_start,
    output logic [CHAR_W-1:0] glyph_addr,
    output logic [2:0]        glyph_col,
    output logic [2:0]        glyph_row,
    input  logic              glyph_bit,
    output logic [11:0]       pixel_out,
    output logic              valid
);
    localparam int unsigned CW = CIW + 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned RW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [11:0] CELL_W = 12'(5 << SCALE_SHIFT);
    localparam logic [11:0] CELL_H = 12'(7 << SCALE_SHIFT);
    localparam logic [11:0] BOXW   = 12'(BOX_W);
    localparam logic [11:0] PITCH  = 12'(CHAR_PITCH);
    localparam logic [CHAR_W-1:0] BLANK = '1;

    logic [CHAR_W-1:0] chars_q  [NUM_LINES][CHARS_PER_LINE];
    logic [CHAR_W-1:0] chars_d  [NUM_LINES][CHARS_PER_LINE];
    logic [9:0]        org_x_q  [NUM_LINES];
    logic [9:0]        org_x_d  [NUM_LINES];
    logic [9:0]        org_y_q  [NUM_LINES];
    logic [9:0]        org_y_d  [NUM_LINES];
    logic [11:0]       colour_q [NUM_LINES];
    logic [11:0]       colour_d [NUM_LINES];

    logic [BW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [RW-1:0] rframe_q, rframe_d;
    logic [CW-1:0] reveal_q, reveal_d;

    // Stage 1 (glyph ROM address) and stage 2 (ROM data return) registers
    logic [CHAR_W-1:0] glyph_addr_q, glyph_addr_d;
    logic [2:0]        glyph_col_q, glyph_col_d;
    logic [2:0]        glyph_row_q, glyph_row_d;
    logic              ghit1_q, ghit1_d, bhit1_q, bhit1_d;
    logic [LW-1:0]     line1_q, line1_d;
    logic              ghit2_q, ghit2_d, bhit2_q, bhit2_d;
    logic [11:0]       colour2_q, colour2_d;
    logic [11:0]       pixel_q, pixel_d;
    logic              valid_q, valid_d;

    // Stage 0 working signals
    logic              line_hit, box_outer, box_inner;
    logic [11:0]       h12, v12, ox, oy, dx, dy, off, base, bx0, by0;
    logic [CW-1:0]     col;
    logic [CHAR_W-1:0] code;

    // Character and origin storage: writes land on the next edge, so a
    // same-cycle read still sees the old contents.
    always_comb begin
        chars_d  = chars_q;
        org_x_d  = org_x_q;
        org_y_d  = org_y_q;
        colour_d = colour_q;
        if (wr_en) chars_d[wr_line][wr_col] = wr_char;
        if (org_we) begin
            org_x_d[wr_line]  = org_x;
            org_y_d[wr_line]  = org_y;
            colour_d[wr_line] = colour_in;
        end
    end

    // Blink phase and typewriter reveal counters; reveal_start overrides frame_start
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        rframe_d    = rframe_q;
        reveal_d    = reveal_q;
        if (frame_start) begin
            if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        if (reveal_start) begin
            rframe_d = '0;
            reveal_d = '0;
        end else if (frame_start) begin
            if (rframe_q == RW'(REVEAL_FRAMES - 1)) begin
                rframe_d = '0;
                if (reveal_q < CW'(CHARS_PER_LINE)) reveal_d = reveal_q + 1'b1;
            end else begin
                rframe_d = rframe_q + 1'b1;
            end
        end
    end

    // Stage 0: select the line and character cell, and classify glyph and box hits
    always_comb begin
        h12      = {2'b00, h_cnt};
        v12      = {2'b00, v_cnt};
        line_hit = 1'b0;
        line1_d  = '0;
        ox       = '0;
        oy       = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (!line_hit && v12 >= {2'b00, org_y_q[LW'(i)]} &&
                v12 < {2'b00, org_y_q[LW'(i)]} + CELL_H) begin
                line_hit = 1'b1;
                line1_d  = LW'(i);
                ox       = {2'b00, org_x_q[LW'(i)]};
                oy       = {2'b00, org_y_q[LW'(i)]};
            end
        end
        dx   = h12 - ox;
        dy   = v12 - oy;
        // Column by comparison against constant multiples of the pitch; the
        // multiples increase, so the last one passed is the quotient.
        col  = '0;
        base = '0;
        for (int unsigned k = 1; k <= CHARS_PER_LINE; k++) begin
            if (dx >= 12'(k * CHAR_PITCH)) begin
                col  = CW'(k);
                base = 12'(k * CHAR_PITCH);
            end
        end
        off         = dx - base;
        code        = chars_q[line1_d][col[CIW-1:0]];
        glyph_addr_d = code;
        glyph_col_d  = 3'(off >> SCALE_SHIFT);
        glyph_row_d  = 3'(dy >> SCALE_SHIFT);
        ghit1_d = line_hit && (h12 >= ox) && (col < CW'(CHARS_PER_LINE)) &&
                  (off < CELL_W) && (code != BLANK) && (col < reveal_q);

        bx0 = {2'b00, org_x_q[cursor_line]} + 12'(cursor_col) * PITCH;
        by0 = {2'b00, org_y_q[cursor_line]};
        box_outer = (h12 + BOXW >= bx0) && (h12 < bx0 + CELL_W + BOXW) &&
                    (v12 + BOXW >= by0) && (v12 < by0 + CELL_H + BOXW);
        box_inner = (h12 >= bx0) && (h12 < bx0 + CELL_W) &&
                    (v12 >= by0) && (v12 < by0 + CELL_H);
        bhit1_d = cursor_en && blink_on_q && box_outer && !box_inner;
    end

    // Stage 2 carry and final pixel selection: the box beats the glyph
    always_comb begin
        ghit2_d   = ghit1_q;
        bhit2_d   = bhit1_q;
        colour2_d = colour_q[line1_q];
        valid_d   = 1'b0;
        pixel_d   = '0;
        if (bhit2_q) begin
            valid_d = 1'b1;
            pixel_d = 12'hfff;
        end else if (ghit2_q) begin
            valid_d = 1'b1;
            pixel_d = glyph_bit ? colour2_q : 12'h000;
        end
    end

    // All state registers; asynchronous reset also flushes the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                for (int unsigned j = 0; j < CHARS_PER_LINE; j++)
                    chars_q[LW'(i)][CIW'(j)] <= '1;
                org_x_q[LW'(i)]  <= '0;
                org_y_q[LW'(i)]  <= '0;
                colour_q[LW'(i)] <= 12'hfff;
            end
            frame_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            rframe_q     <= '0;
            reveal_q     <= CW'(CHARS_PER_LINE);
            glyph_addr_q <= '0;
            glyph_col_q  <= '0;
            glyph_row_q  <= '0;
            ghit1_q      <= 1'b0;
            bhit1_q      <= 1'b0;
            line1_q      <= '0;
            ghit2_q      <= 1'b0;
            bhit2_q      <= 1'b0;
            colour2_q    <= '0;
            pixel_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            chars_q      <= chars_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            colour_q     <= colour_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_on_q   <= blink_on_d;
            rframe_q     <= rframe_d;
            reveal_q     <= reveal_d;
            glyph_addr_q <= glyph_addr_d;
            glyph_col_q  <= glyph_col_d;
            glyph_row_q  <= glyph_row_d;
            ghit1_q      <= ghit1_d;
            bhit1_q      <= bhit1_d;
            line1_q      <= line1_d;
            ghit2_q      <= ghit2_d;
            bhit2_q      <= bhit2_d;
            colour2_q    <= colour2_d;
            pixel_q      <= pixel_d;
            valid_q      <= valid_d;
        end
    end

    assign glyph_addr = glyph_addr_q;
    assign glyph_col  = glyph_col_q;
    assign glyph_row  = glyph_row_q;
    assign pixel_out  = pixel_q;
    assign valid      = valid_q;
endmodule

// File: tb/tb_txt_overlay_engine.sv
// Directed bench for txt_overlay_engine. The ROM model is synchronous and
// returns 1 for every cell except for char code 20, which is entirely empty.
module tb_txt_overlay_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        frame_start, wr_en, org_we, cursor_en, reveal_start;
    logic [0:0]  wr_line, cursor_line;
    logic [2:0]  wr_col, cursor_col;
    logic [5:0]  wr_char;
    logic [9:0]  org_x, org_y;
    logic [11:0] colour_in;
    logic [5:0]  glyph_addr;
    logic [2:0]  glyph_col, glyph_row;
    logic        glyph_bit;
    logic [11:0] pixel_out;
    logic        valid;

    int checks   = 0;
    int failures = 0;
    logic [5:0]  p_ga;
    logic [2:0]  p_gc, p_gr;
    logic        p_vld;
    logic [11:0] p_pix;

    txt_overlay_engine #(
        .NUM_LINES(2), .CHARS_PER_LINE(8), .CHAR_W(6), .SCALE_SHIFT(4),
        .CHAR_PITCH(90), .BOX_W(10), .BLINK_FRAMES(32), .REVEAL_FRAMES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_start(frame_start), .wr_en(wr_en), .wr_line(wr_line),
        .wr_col(wr_col), .wr_char(wr_char), .org_we(org_we), .org_x(org_x),
        .org_y(org_y), .colour_in(colour_in), .cursor_en(cursor_en),
        .cursor_line(cursor_line), .cursor_col(cursor_col),
        .reveal_start(reveal_start), .glyph_addr(glyph_addr),
        .glyph_col(glyph_col), .glyph_row(glyph_row), .glyph_bit(glyph_bit),
        .pixel_out(pixel_out), .valid(valid)
    );

    always #5 clk = ~clk;

    // Synchronous glyph ROM model
    always @(posedge clk) glyph_bit <= (glyph_addr == 6'd20) ? 1'b0 : 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge
    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        h_cnt = x;
        v_cnt = y;
        @(posedge clk); #1;
        p_ga = glyph_addr;
        p_gc = glyph_col;
        p_gr = glyph_row;
        repeat (2) @(posedge clk);
        #1;
        p_vld = valid;
        p_pix = pixel_out;
    endtask

    task automatic write_char(input logic [0:0] ln, input logic [2:0] c, input logic [5:0] code);
        wr_en = 1'b1; wr_line = ln; wr_col = c; wr_char = code;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic write_org(input logic [0:0] ln, input logic [9:0] x, input logic [9:0] y,
                             input logic [11:0] col);
        org_we = 1'b1; wr_line = ln; org_x = x; org_y = y; colour_in = col;
        @(posedge clk); #1;
        org_we = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        h_cnt = '0; v_cnt = '0; frame_start = 0; wr_en = 0; org_we = 0;
        cursor_en = 0; reveal_start = 0; wr_line = '0; cursor_line = '0;
        wr_col = '0; cursor_col = '0; wr_char = '0; org_x = '0; org_y = '0;
        colour_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_pixel", 32'(pixel_out), 32'h0);
        rst_n = 1'b1;
        probe(10'd0, 10'd0);
        check("blank_after_reset", 32'(p_vld), 32'h0);

        // Line 0 at (160,28) showing "GAME"
        write_org(1'b0, 10'd160, 10'd28, 12'hfff);
        write_char(1'b0, 3'd0, 6'd16);
        write_char(1'b0, 3'd1, 6'd10);
        write_char(1'b0, 3'd2, 6'd22);
        write_char(1'b0, 3'd3, 6'd14);
        probe(10'd160, 10'd28);
        check("origin_valid", 32'(p_vld), 32'h1);
        check("origin_pixel", 32'(p_pix), 32'hfff);
        probe(10'd240, 10'd28);
        check("gap_valid", 32'(p_vld), 32'h0);
        probe(10'd250, 10'd28);
        check("col1_valid", 32'(p_vld), 32'h1);
        probe(10'd239, 10'd139);
        check("corner_valid", 32'(p_vld), 32'h1);
        check("corner_gcol", 32'(p_gc), 32'd4);
        check("corner_grow", 32'(p_gr), 32'd6);
        probe(10'd160, 10'd140);
        check("below_valid", 32'(p_vld), 32'h0);
        probe(10'd150, 10'd28);
        check("left_valid", 32'(p_vld), 32'h0);

        // Cursor box around line 0 column 1
        cursor_en = 1'b1; cursor_line = 1'b0; cursor_col = 3'd1;
        probe(10'd245, 10'd28);
        check("box_valid", 32'(p_vld), 32'h1);
        check("box_pixel", 32'(p_pix), 32'hfff);
        probe(10'd260, 10'd18);
        check("box_top_edge", 32'(p_vld), 32'h1);
        probe(10'd260, 10'd17);
        check("box_above_edge", 32'(p_vld), 32'h0);
        frames(32);
        probe(10'd245, 10'd28);
        check("blink_off", 32'(p_vld), 32'h0);
        frames(32);
        probe(10'd245, 10'd28);
        check("blink_on_valid", 32'(p_vld), 32'h1);
        check("blink_on_pixel", 32'(p_pix), 32'hfff);
        cursor_en = 1'b0;

        // Typewriter reveal
        reveal_start = 1'b1;
        @(posedge clk); #1;
        reveal_start = 1'b0;
        frames(8);
        probe(10'd250, 10'd28);
        check("reveal2_col1", 32'(p_vld), 32'h1);
        probe(10'd340, 10'd28);
        check("reveal2_col2", 32'(p_vld), 32'h0);
        frames(32);
        probe(10'd430, 10'd28);
        check("reveal_full_col3", 32'(p_vld), 32'h1);
        reveal_start = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1;
        reveal_start = 1'b0; frame_start = 1'b0;
        probe(10'd160, 10'd28);
        check("reveal_reset_wins", 32'(p_vld), 32'h0);
        frames(4);
        probe(10'd160, 10'd28);
        check("reveal1_col0", 32'(p_vld), 32'h1);
        frames(28);

        // Overlapping lines: line 0 wins where both hit
        write_org(1'b1, 10'd160, 10'd100, 12'h0f0);
        write_char(1'b1, 3'd0, 6'd12);
        probe(10'd160, 10'd130);
        check("overlap_line0", 32'(p_pix), 32'hfff);
        probe(10'd160, 10'd150);
        check("line1_colour", 32'(p_pix), 32'h0f0);

        // A write in the cycle the slot is read returns the old glyph
        h_cnt = 10'd160; v_cnt = 10'd28;
        wr_en = 1'b1; wr_line = 1'b0; wr_col = 3'd0; wr_char = 6'd20;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("same_cycle_addr", 32'(glyph_addr), 32'd16);
        repeat (2) @(posedge clk);
        #1;
        check("same_cycle_pixel", 32'(pixel_out), 32'hfff);
        probe(10'd160, 10'd28);
        check("new_char_addr", 32'(p_ga), 32'd20);
        check("new_char_valid", 32'(p_vld), 32'h1);
        check("new_char_pixel", 32'(p_pix), 32'h000);

        // Asynchronous reset in the middle of a line
        probe(10'd250, 10'd28);
        check("pre_reset_valid", 32'(p_vld), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(valid), 32'h0);
        check("async_reset_pixel", 32'(pixel_out), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        probe(10'd160, 10'd28);
        check("post_reset_blank", 32'(p_vld), 32'h0);
        probe(10'd0, 10'd0);
        check("post_reset_origin", 32'(p_vld), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
